// File: rtl/fp_flags_pkg.sv
// Shared FP class codes, exception flag indices and format helpers.
// Pure declarations; no latency.
// No flow control.
package fp_flags_pkg;

    typedef logic [2:0] fp_class_t;

    localparam fp_class_t NORMAL    = 3'd0;
    localparam fp_class_t SUBNORMAL = 3'd1;
    localparam fp_class_t ZERO      = 3'd2;
    localparam fp_class_t INFINITY  = 3'd3;
    localparam fp_class_t QNAN      = 3'd4;
    localparam fp_class_t SNAN      = 3'd5;

    localparam int INVALID      = 0;
    localparam int DIVIDEBYZERO = 1;
    localparam int OVERFLOW     = 2;
    localparam int UNDERFLOW    = 3;
    localparam int INEXACT      = 4;
    localparam int NFLAGS       = 5;

    localparam int NEXP_DEF = 8;
    localparam int NSIG_DEF = 7;
    localparam int BIAS     = (1 << (NEXP_DEF - 1)) - 1;
    localparam int EMAX     = BIAS;
    localparam int EMIN     = 1 - BIAS;

    typedef enum logic {
        TRAP_IDLE = 1'b0,
        TRAP_PEND = 1'b1
    } trap_state_t;

    // Patterns are right-aligned in 64 bits; callers slice to 1+nexp+nsig.
    function automatic logic [63:0] inf_bits(input int nexp, input int nsig);
        return ((64'd1 << nexp) - 64'd1) << nsig;
    endfunction

    function automatic logic [63:0] qnan_bits(input int nexp, input int nsig);
        return inf_bits(nexp, nsig) | (64'd1 << (nsig - 1));
    endfunction

    function automatic logic [63:0] zero_bits(input logic sign, input int nexp, input int nsig);
        return {63'd0, sign} << (nexp + nsig);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Classifies one result word into a 3-bit class code; sign is ignored.
// Combinational, zero latency.
// No flow control.
module fp_classify
    import fp_flags_pkg::*;
#(
    parameter int NEXP = 8,
    parameter int NSIG = 7
) (
    input  logic [NEXP+NSIG:0] result,
    output logic [2:0]         cls
);

    logic [NEXP-1:0] expo;
    logic [NSIG-1:0] frac;
    logic            unused_sign;

    assign expo        = result[NEXP+NSIG-1:NSIG];
    assign frac        = result[NSIG-1:0];
    assign unused_sign = result[NEXP+NSIG];

    always_comb begin
        cls = NORMAL;
        if (&expo) begin
            if (frac == '0)
                cls = INFINITY;
            else if (frac[NSIG-1])
                cls = QNAN;
            else
                cls = SNAN;
        end else if (expo == '0) begin
            cls = (frac == '0) ? ZERO : SUBNORMAL;
        end
    end

endmodule

// File: rtl/fp_exception_tracker.sv
// Per-lane class registers, sticky flags, saturating event counters and trap FSM.
// All outputs registered, 1 cycle after the sampled inputs.
// No backpressure; every lane may be valid every cycle.
module fp_exception_tracker
    import fp_flags_pkg::*;
#(
    parameter int NEXP   = 8,
    parameter int NSIG   = 7,
    parameter int NLANES = 2,
    parameter int CNTW   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NLANES-1:0]             in_valid,
    input  logic [NLANES*(1+NEXP+NSIG)-1:0] in_result,
    input  logic [NLANES*NFLAGS-1:0]      in_exc,
    input  logic [NFLAGS-1:0]             trap_en,
    input  logic                          clr,
    input  logic                          irq_ack,
    output logic [NLANES-1:0]             cls_valid,
    output logic [NLANES*3-1:0]           cls,
    output logic [NFLAGS-1:0]             sticky,
    output logic [NFLAGS*CNTW-1:0]        cnt,
    output logic                          irq,
    output logic [NFLAGS-1:0]             trap_cause
);

    localparam int W = 1 + NEXP + NSIG;

    logic [NLANES*3-1:0]    lane_cls;
    logic [NFLAGS-1:0]      ev;
    logic [NFLAGS-1:0]      hit;
    logic [3:0]             ev_num  [NFLAGS];
    logic [CNTW+3:0]        cnt_sum [NFLAGS];
    logic [NFLAGS*CNTW-1:0] cnt_nxt;
    trap_state_t            state;

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        fp_classify #(
            .NEXP (NEXP),
            .NSIG (NSIG)
        ) u_classify (
            .result (in_result[l*W +: W]),
            .cls    (lane_cls[l*3 +: 3])
        );
    end

    // Per-flag count of valid lanes reporting it (up to 8 lanes fits 4 bits).
    always_comb begin
        for (int f = 0; f < NFLAGS; f++) begin
            ev_num[f] = 4'd0;
            for (int l = 0; l < NLANES; l++) begin
                if (in_valid[l] && in_exc[l*NFLAGS+f])
                    ev_num[f] = ev_num[f] + 4'd1;
            end
            ev[f] = (ev_num[f] != 4'd0);
        end
    end

    assign hit = ev & trap_en;

    // Extra headroom bits catch the carry so the counter clamps instead of wrapping.
    always_comb begin
        cnt_nxt = '0;
        for (int f = 0; f < NFLAGS; f++) begin
            cnt_sum[f] = {4'd0, (clr ? {CNTW{1'b0}} : cnt[f*CNTW +: CNTW])}
                       + {{CNTW{1'b0}}, ev_num[f]};
            cnt_nxt[f*CNTW +: CNTW] = (cnt_sum[f][CNTW+3:CNTW] != 4'd0)
                                    ? {CNTW{1'b1}} : cnt_sum[f][CNTW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_valid <= '0;
            cls       <= '0;
            sticky    <= '0;
            cnt       <= '0;
        end else begin
            cls_valid <= in_valid;
            for (int l = 0; l < NLANES; l++) begin
                if (in_valid[l])
                    cls[l*3 +: 3] <= lane_cls[l*3 +: 3];
            end
            sticky <= (clr ? {NFLAGS{1'b0}} : sticky) | ev;
            cnt    <= cnt_nxt;
        end
    end

    // An ack coinciding with a fresh enabled event restarts the trap on that event alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= TRAP_IDLE;
            irq        <= 1'b0;
            trap_cause <= '0;
        end else begin
            case (state)
                TRAP_IDLE: begin
                    if (hit != '0) begin
                        state      <= TRAP_PEND;
                        irq        <= 1'b1;
                        trap_cause <= hit;
                    end
                end
                TRAP_PEND: begin
                    if (irq_ack) begin
                        if (hit != '0) begin
                            trap_cause <= hit;
                        end else begin
                            state      <= TRAP_IDLE;
                            irq        <= 1'b0;
                            trap_cause <= '0;
                        end
                    end else begin
                        trap_cause <= trap_cause | hit;
                    end
                end
                default: begin
                    state      <= TRAP_IDLE;
                    irq        <= 1'b0;
                    trap_cause <= '0;
                end
            endcase
        end
    end

endmodule
